branch_resolve_unit: RTL
========================

BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter FLUSH_CYCLES, default 2: number of cycles flush is held after a mispredict, legal range 1..7.
REQ-002 Parameter CNT_W, default 16: width of the statistics counters.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port in_valid, input, 1: decoded instruction present this cycle.
REQ-006 Port opcode, input, 7: instruction opcode.
REQ-007 Port funct3, input, 3: branch condition select.
REQ-008 Port pc, input, 32: word address of the instruction.
REQ-009 Port rs1_val and rs2_val, input, 32 each: operand values.
REQ-010 Port imm, input, 32: sign-extended, word-scaled offset.
REQ-011 Port pred_taken, input, 1: fetch prediction carried with the instruction.
REQ-012 Port pred_target, input, 32: fetch-predicted target.
REQ-013 Port HALTED, input, 1: pipeline hold.
REQ-014 Port valid_exe, output, 1: resolution result valid for fetch.
REQ-015 Port branch_status_exe, output, 1: resolved taken.
REQ-016 Port jump_addr_exe, output, 32: resolved target.
REQ-017 Port flush, output, 1: squash younger instructions.
REQ-018 Port redirect_pc, output, 32: correct next PC.
REQ-019 Port link_valid, output, 1: link write is valid.
REQ-020 Port link_data, output, 32: link value.
REQ-021 Port br_count and mp_count, output, CNT_W each: statistics counters.

Function
REQ-022 Opcodes: B=1100011 (conditional), JAL=1101111, JALR=1100111; any other opcode is a non-branch and produces no output pulse.
REQ-023 Conditions by funct3: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE; 010 and 011 are never taken.
REQ-024 Targets: B and JAL use pc+imm; JALR uses (rs1_val+imm) with bit 0 cleared; all additions are modulo 2^32.
REQ-025 Fall-through address is pc+1, wrapping from 0xFFFFFFFF to 0.
REQ-026 Latency: a branch accepted in cycle N drives valid_exe, branch_status_exe, jump_addr_exe, redirect_pc, link_valid and link_data as a one-cycle registered pulse in cycle N+1.
REQ-027 Mispredict is declared in either case:
- taken, and (pred_taken=0 or pred_target≠target);
- not taken, and pred_taken=1.
REQ-028 redirect_pc is the target when taken, otherwise the fall-through address.
REQ-029 JAL and JALR are always taken, with link_data=pc+1; B never asserts link_valid.
REQ-030 FSM states: RUN and FLUSH.
- A mispredict in RUN goes to FLUSH; flush is asserted from N+1 for FLUSH_CYCLES cycles.
- FLUSH then returns to RUN.
REQ-031 In FLUSH, in_valid is ignored: no result pulse and no counter update.
REQ-032 When HALTED=1 and state is RUN, inputs are not accepted and all state holds. Output pulses still last exactly one cycle.
REQ-033 When HALTED=1 and state is FLUSH, the flush countdown continues.
REQ-034 br_count increments by 1 per accepted B/JAL/JALR; mp_count increments by 1 per mispredict; both saturate at all-ones.

Reset
REQ-035 When rst=1 at a clock edge, the unit SHALL enter RUN, clear all outputs and counters, and clear the flush countdown. This takes priority over every other event, including a reset asserted mid-FLUSH.

Structure
REQ-036 Opcode constants, funct3 codes and FSM state encodings SHALL reside in the shared package rv32im_pkg.
REQ-037 Condition evaluation SHALL be a sub-module branch_cond_eval (combinational) instantiated once.

Verification
REQ-038 BEQ at pc=0x10, rs1=rs2=5, imm=4, pred_taken=1, pred_target=0x14:
- next cycle: valid_exe=1, branch_status_exe=1, jump_addr_exe=0x14;
- flush=0; br_count=1; mp_count=0.
REQ-039 BLT with rs1=0xFFFFFFFF, rs2=1, pred_taken=0: taken, so mispredict:
- flush high for exactly 2 cycles;
- redirect_pc=pc+imm;
- an in_valid branch during the flush produces no pulse and no count.
REQ-040 BLTU, same operands as REQ-039, pred_taken=1: not taken, so mispredict with redirect_pc=pc+1.
REQ-041 JALR at pc=0x20, rs1=0x101, imm=2, pred_target=0x102:
- target 0x102; no mispredict;
- link_valid=1, link_data=0x21.
REQ-042 rst asserted in the first FLUSH cycle:
- next cycle: flush=0, all outputs 0, counters 0;
- a following branch resolves normally.
REQ-043 Force br_count to its saturation value:
- it stays at all-ones on further branches;
- HALTED=1 with in_valid=1 produces no pulse and no count.

Source files
------------

// File: rtl/rv32im_pkg.sv
// rtl/rv32im_pkg.sv - shared opcode, condition and FSM encodings for branch resolution
package rv32im_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_EQ  = 3'b000;
  localparam logic [2:0] F3_NE  = 3'b001;
  localparam logic [2:0] F3_LT  = 3'b100;
  localparam logic [2:0] F3_GE  = 3'b101;
  localparam logic [2:0] F3_LTU = 3'b110;
  localparam logic [2:0] F3_GEU = 3'b111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } brs_state_t;

  function automatic logic is_branch_op(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// rtl/branch_resolve_unit_if.sv - decode-to-resolve bus with results back to fetch
interface branch_resolve_unit_if #(
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic [31:0]      pc;
  logic [31:0]      rs1_val;
  logic [31:0]      rs2_val;
  logic [31:0]      imm;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             HALTED;

  logic             valid_exe;
  logic             branch_status_exe;
  logic [31:0]      jump_addr_exe;
  logic             flush;
  logic [31:0]      redirect_pc;
  logic             link_valid;
  logic [31:0]      link_data;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] mp_count;

  modport master (
    output in_valid, opcode, funct3, pc, rs1_val, rs2_val, imm,
           pred_taken, pred_target, HALTED,
    input  valid_exe, branch_status_exe, jump_addr_exe, flush, redirect_pc,
           link_valid, link_data, br_count, mp_count
  );

  modport slave (
    input  in_valid, opcode, funct3, pc, rs1_val, rs2_val, imm,
           pred_taken, pred_target, HALTED,
    output valid_exe, branch_status_exe, jump_addr_exe, flush, redirect_pc,
           link_valid, link_data, br_count, mp_count
  );
endinterface

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational conditional-branch comparator
module branch_cond_eval
  import rv32im_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        taken
);

  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_EQ:   taken = (a == b);
      F3_NE:   taken = (a != b);
      F3_LT:   taken = ($signed(a) <  $signed(b));
      F3_GE:   taken = ($signed(a) >= $signed(b));
      F3_LTU:  taken = (a <  b);
      F3_GEU:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - resolves B/JAL/JALR, detects mispredicts, drives flush and stats
module branch_resolve_unit
  import rv32im_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst,
  branch_resolve_unit_if.slave bus
);

  brs_state_t  state, next_state;
  logic [2:0]  flush_cnt, next_flush_cnt;

  logic        cond_taken;
  logic        is_jump;
  logic        accept;
  logic        taken;
  logic        mispredict;
  logic [31:0] target;
  logic [31:0] fall_through;

  branch_cond_eval u_cond (
    .funct3 (bus.funct3),
    .a      (bus.rs1_val),
    .b      (bus.rs2_val),
    .taken  (cond_taken)
  );

  assign is_jump      = (bus.opcode == OP_JAL) || (bus.opcode == OP_JALR);
  assign accept       = bus.in_valid && (state == ST_RUN) && !bus.HALTED
                        && is_branch_op(bus.opcode);
  assign taken        = is_jump || cond_taken;
  assign fall_through = bus.pc + 32'd1;

  always_comb begin
    target = bus.pc + bus.imm;
    if (bus.opcode == OP_JALR)
      target = (bus.rs1_val + bus.imm) & ~32'd1;
  end

  // A taken branch is wrong if fetch either did not take it or went elsewhere.
  assign mispredict = taken ? (!bus.pred_taken || (bus.pred_target != target))
                            : bus.pred_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      flush_cnt <= 3'd0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_flush_cnt;
    end
  end

  // The countdown ignores HALTED so the squash window never stretches.
  always_comb begin
    next_state     = state;
    next_flush_cnt = flush_cnt;
    case (state)
      ST_RUN: begin
        if (accept && mispredict) begin
          next_state     = ST_FLUSH;
          next_flush_cnt = 3'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == 3'd0)
          next_state = ST_RUN;
        else
          next_flush_cnt = flush_cnt - 3'd1;
      end
      default: next_state = ST_RUN;
    endcase
  end

  always_comb begin
    bus.flush = (state == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid_exe         <= 1'b0;
      bus.branch_status_exe <= 1'b0;
      bus.jump_addr_exe     <= 32'd0;
      bus.redirect_pc       <= 32'd0;
      bus.link_valid        <= 1'b0;
      bus.link_data         <= 32'd0;
    end else if (accept) begin
      bus.valid_exe         <= 1'b1;
      bus.branch_status_exe <= taken;
      bus.jump_addr_exe     <= target;
      bus.redirect_pc       <= taken ? target : fall_through;
      bus.link_valid        <= is_jump;
      bus.link_data         <= is_jump ? fall_through : 32'd0;
    end else begin
      bus.valid_exe         <= 1'b0;
      bus.branch_status_exe <= 1'b0;
      bus.jump_addr_exe     <= 32'd0;
      bus.redirect_pc       <= 32'd0;
      bus.link_valid        <= 1'b0;
      bus.link_data         <= 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.br_count <= '0;
      bus.mp_count <= '0;
    end else begin
      if (accept && (bus.br_count != {CNT_W{1'b1}}))
        bus.br_count <= bus.br_count + CNT_W'(1);
      if (accept && mispredict && (bus.mp_count != {CNT_W{1'b1}}))
        bus.mp_count <= bus.mp_count + CNT_W'(1);
    end
  end

endmodule
